bpm_test_packet_gen: RTL and testbench
======================================

BPM_TEST_PACKET_GEN -- requirements
Module: bpm_test_packet_gen

Interface
REQ-001 Parameter NUM_DATA_WORDS, default 3, data words per packet; SHALL be in range 1..255.
REQ-002 Parameter INDEX_WIDTH, default 5, header index field width; SHALL be in range 1..6.
REQ-003 Parameter MAX_CHANNELS, default 4, packets per FA cycle upper bound; SHALL be in range 1..2^INDEX_WIDTH.
REQ-004 Parameter HEADER_MAGIC, default 16'hA5BE, header bits [31:16].
REQ-005 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-006 auroraUserClk  in  1  sole clock.
REQ-007 auroraReset_n  in  1  asynchronous active-low reset.
REQ-008 auroraFAstrobe  in  1  single-cycle FA cycle start.
REQ-009 auroraChannelUp  in  1  link up.
REQ-010 enable  in  1  generator enable.
REQ-011 firstIndex  in  INDEX_WIDTH  index of channel 0.
REQ-012 channelCount  in  CW=$clog2(MAX_CHANNELS+1)  packets per cycle.
REQ-013 BPM_TEST_AXI_STREAM_TX_tdata / _tvalid / _tlast  out  32/1/1  AXI stream.
REQ-014 BPM_TEST_AXI_STREAM_TX_tready  in  1  AXI stream ready.
REQ-015 busy  out  1  burst in progress.
REQ-016 overrunStrobe / abortStrobe  out  1/1  single-cycle event pulses.
REQ-017 packetsSent  out  16  completed packets, wraps.

Function
REQ-018 16-bit cycleCount SHALL increment, wrapping, on every auroraFAstrobe while auroraChannelUp=1, regardless of enable or busy.
REQ-019 States SHALL be IDLE, HEADER, DATA.
REQ-020 IDLE->HEADER when auroraFAstrobe & auroraChannelUp & enable & channelCount!=0; on that edge SHALL latch cycleCount pre-increment value (cyc), firstIndex, and min(channelCount, MAX_CHANNELS) (nch); channel c=0.
REQ-021 Strobe accepted in IDLE with channelCount=0 SHALL send nothing and SHALL NOT pulse overrunStrobe.
REQ-022 tvalid SHALL be 1 exactly in HEADER and DATA; a beat transfers on tvalid & tready.
REQ-023 Once tvalid=1, tdata/tlast SHALL hold stable until transfer (except REQ-029).
REQ-024 Index of channel c SHALL be (firstIndex_latched + c) mod 2^INDEX_WIDTH.
REQ-025 Header word: [31:16]=HEADER_MAGIC, [15:10+INDEX_WIDTH]=0, [9+INDEX_WIDTH:10]=index, [9:0]=cyc[9:0]; tlast=0.
REQ-026 Data word k (1..NUM_DATA_WORDS): {cyc[15:0], index zero-extended to 8 bits, k[7:0]}; tlast=1 only at k=NUM_DATA_WORDS.
REQ-027 HEADER->DATA(k=1) on transfer; DATA k->k+1 on transfer; after last word: packetsSent++, then c+1<nch -> HEADER (next cycle, no gap), else IDLE.
REQ-028 auroraFAstrobe while not IDLE SHALL be ignored for packet generation and SHALL pulse overrunStrobe one cycle later.
REQ-029 auroraChannelUp=0 in HEADER/DATA SHALL force IDLE next edge, tvalid=0 that edge, abortStrobe pulse one cycle, no packetsSent increment.
REQ-030 enable deasserted mid-burst SHALL NOT abort; burst completes.
REQ-031 busy SHALL equal (state != IDLE).
REQ-032 Latency: first header tvalid SHALL rise the edge after the accepted strobe.

Reset
REQ-033 auroraReset_n=0 SHALL immediately force IDLE, tvalid=0, tlast=0, tdata=0, busy=0, overrunStrobe=0, abortStrobe=0, packetsSent=0, cycleCount=0.
REQ-034 Reset mid-packet SHALL discard the packet; first packet after release SHALL start on the next accepted strobe.

Verification
REQ-035 Defaults, channelCount=1, firstIndex=1, tready=1, first strobe -> 4 beats: 32'hA5BE0400, 32'h00000101, 32'h00000102, 32'h00000103 (tlast on last); packetsSent=1.
REQ-036 channelCount=3, firstIndex=31, tready=1 -> 12 back-to-back beats, indices 31, 0, 1; packetsSent +=3.
REQ-037 tready random 50% over 200 cycles -> beat sequence identical to tready=1 case, tdata stable while stalled.
REQ-038 Strobe during burst (channelCount=4, tready=0) -> overrunStrobe one pulse, burst unchanged, next strobe accepted after IDLE.
REQ-039 auroraChannelUp dropped at data word 2 -> tvalid 0 next edge, abortStrobe one pulse, packetsSent unchanged; cycleCount frozen until link up.
REQ-040 channelCount=7 with MAX_CHANNELS=4 -> exactly 4 packets; channelCount=0 -> none, no overrun.

Source files
------------

// File: rtl/bpm_test_packet_gen.sv
// bpm_test_packet_gen: emits per-FA-cycle bursts of test packets (header + data words) on an AXI stream.
module bpm_test_packet_gen #(
  parameter int          NUM_DATA_WORDS = 3,
  parameter int          INDEX_WIDTH    = 5,
  parameter int          MAX_CHANNELS   = 4,
  parameter logic [15:0] HEADER_MAGIC   = 16'hA5BE,
  localparam int         CW             = $clog2(MAX_CHANNELS + 1)
) (
  input  logic                   auroraUserClk,
  input  logic                   auroraReset_n,
  input  logic                   auroraFAstrobe,
  input  logic                   auroraChannelUp,
  input  logic                   enable,
  input  logic [INDEX_WIDTH-1:0] firstIndex,
  input  logic [CW-1:0]          channelCount,
  output logic [31:0]            BPM_TEST_AXI_STREAM_TX_tdata,
  output logic                   BPM_TEST_AXI_STREAM_TX_tvalid,
  output logic                   BPM_TEST_AXI_STREAM_TX_tlast,
  input  logic                   BPM_TEST_AXI_STREAM_TX_tready,
  output logic                   busy,
  output logic                   overrunStrobe,
  output logic                   abortStrobe,
  output logic [15:0]            packetsSent
);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CHANNELS);
  localparam logic [7:0]    LAST = 8'(NUM_DATA_WORDS);
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
  state_t state, state_nxt;
  logic [15:0] cycle_count, cyc, hdr_lo;
  logic [INDEX_WIDTH-1:0] idx;
  logic [CW-1:0] rem;
  logic [7:0] k;
  logic xfer, accept, last;
  assign busy   = state != IDLE;
  assign xfer   = busy & BPM_TEST_AXI_STREAM_TX_tready;
  assign accept = !busy & auroraFAstrobe & auroraChannelUp & enable & (channelCount != '0);
  assign last   = state == DATA && k == LAST;
  assign hdr_lo = (16'(idx) << 10) | {6'd0, cyc[9:0]};
  assign BPM_TEST_AXI_STREAM_TX_tvalid = busy;
  assign BPM_TEST_AXI_STREAM_TX_tlast  = last;
  assign BPM_TEST_AXI_STREAM_TX_tdata  = state == HEADER ? {HEADER_MAGIC, hdr_lo} :
                                         state == DATA   ? {cyc, 8'(idx), k} : '0;
  // Link loss wins over everything, including a beat completing on the same edge.
  always_comb begin
    state_nxt = state;
    if (busy && !auroraChannelUp) state_nxt = IDLE;
    else if (accept) state_nxt = HEADER;
    else if (xfer) state_nxt = state == HEADER ? DATA : !last ? DATA : rem != '0 ? HEADER : IDLE;
  end
  always_ff @(posedge auroraUserClk or negedge auroraReset_n)
    if (!auroraReset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
    if (!auroraReset_n) begin
      cycle_count   <= '0;
      cyc           <= '0;
      idx           <= '0;
      rem           <= '0;
      k             <= '0;
      packetsSent   <= '0;
      overrunStrobe <= 1'b0;
      abortStrobe   <= 1'b0;
    end else begin
      overrunStrobe <= auroraFAstrobe & busy;
      abortStrobe   <= busy & !auroraChannelUp;
      if (auroraFAstrobe && auroraChannelUp) cycle_count <= cycle_count + 16'd1;
      if (accept) begin
        cyc <= cycle_count;
        idx <= firstIndex;
        rem <= (channelCount > MAXC ? MAXC : channelCount) - CW'(1);
      end
      if (xfer && auroraChannelUp) begin
        k <= state == HEADER ? 8'd1 : k + 8'd1;
        if (last) begin
          packetsSent <= packetsSent + 16'd1;
          idx         <= idx + INDEX_WIDTH'(1);
          rem         <= rem - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_bpm_test_packet_gen.sv
// tb_bpm_test_packet_gen: randomized and directed stimulus checked against a beat-queue reference model.
module tb_bpm_test_packet_gen;
  logic clk = 0, rst_n = 1, fa = 0, up = 1, en = 1, tready = 1;
  logic [4:0] fi = 0;
  logic [2:0] cc = 0;
  logic [31:0] tdata;
  logic tvalid, tlast, busy, ov, ab;
  logic [15:0] sent;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [31:0] d; logic l;} beat_t;
  beat_t q[$];
  int cyc_m = 0, pk_m = 0;
  logic exp_ov = 0, exp_ab = 0;

  bpm_test_packet_gen dut (
    .auroraUserClk(clk), .auroraReset_n(rst_n), .auroraFAstrobe(fa), .auroraChannelUp(up),
    .enable(en), .firstIndex(fi), .channelCount(cc),
    .BPM_TEST_AXI_STREAM_TX_tdata(tdata), .BPM_TEST_AXI_STREAM_TX_tvalid(tvalid),
    .BPM_TEST_AXI_STREAM_TX_tlast(tlast), .BPM_TEST_AXI_STREAM_TX_tready(tready),
    .busy(busy), .overrunStrobe(ov), .abortStrobe(ab), .packetsSent(sent));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Expected beats of one burst, built straight from the packet format rules.
  task automatic push_burst(input int first, input int count, input int c);
    int n = count > 4 ? 4 : count;
    for (int ch = 0; ch < n; ch++) begin
      int ix = (first + ch) % 32;
      q.push_back('{32'hA5BE0000 + ix * 1024 + c % 1024, 1'b0});
      for (int w = 1; w <= 3; w++) q.push_back('{(c % 65536) * 65536 + ix * 256 + w, w == 3});
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      check("rst_tvalid", 32'(tvalid), 0);
      check("rst_tdata", tdata, 0);
      check("rst_tlast", 32'(tlast), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ov", 32'(ov), 0);
      check("rst_ab", 32'(ab), 0);
      check("rst_sent", 32'(sent), 0);
      q.delete();
      cyc_m = 0; pk_m = 0; exp_ov = 0; exp_ab = 0;
    end else begin
      check("tvalid", 32'(tvalid), 32'(q.size() != 0));
      check("busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("tdata", tdata, q[0].d);
        check("tlast", 32'(tlast), 32'(q[0].l));
      end
      check("overrun", 32'(ov), 32'(exp_ov));
      check("abort", 32'(ab), 32'(exp_ab));
      check("sent", 32'(sent), pk_m % 65536);
      exp_ov = fa && q.size() != 0;
      exp_ab = q.size() != 0 && !up;
      if (q.size() != 0 && !up) q.delete();
      else if (q.size() != 0 && tready) begin
        if (q[0].l) pk_m++;
        void'(q.pop_front());
      end else if (q.size() == 0 && fa && up && en && cc != 0) push_burst(int'(fi), int'(cc), cyc_m);
      if (fa && up) cyc_m++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    fa = 1; step(1); fa = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    step(3);
    rst_n = 1;
    step(2);
    cc = 1; fi = 1; strobe(); step(8);
    cc = 3; fi = 31; strobe(); step(16);
    for (int i = 0; i < 200; i++) begin
      tready = 1'($urandom % 2);
      fa = !fa && ($urandom % 6 == 0);
      cc = 3'($urandom_range(0, 7));
      fi = 5'($urandom);
      step(1);
    end
    fa = 0; tready = 1; step(30);
    tready = 0; cc = 4; fi = 7; strobe(); step(3);
    strobe(); step(3);
    tready = 1; step(25);
    cc = 2; strobe(); step(12);
    cc = 2; fi = 3; strobe(); step(2);
    up = 0; step(2);
    strobe(); step(2);
    up = 1; step(2);
    cc = 1; strobe(); step(8);
    cc = 7; fi = 30; strobe(); step(22);
    cc = 0; strobe(); step(5);
    cc = 2; strobe(); step(3);
    #2 rst_n = 0;
    step(2);
    rst_n = 1; step(2);
    cc = 1; fi = 9; strobe(); step(8);
    cc = 4; strobe(); step(2);
    en = 0; step(20);
    en = 1; step(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
